pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the accumulator CPU. Sits beside `iFetch`, driving its `enable` and branch-load inputs and the IF/ID and ID/EX pipeline-register controls. Detects load-use hazards and taken branches and inserts stalls, bubbles and flushes. Also handles start-up and halt so the fetch stage never free-runs.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_cnt.sv | 29 ++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state
// encodings (as seen on oState) and the width of the stall/flush counter.
package pipe_ctrl_pkg;

  // Counter covers max(STALL_CYCLES, BR_PENALTY) - 1, i.e. up to 3.
  localparam int PC_CNT_W = 2;
  localparam int PC_ST_W  = 3;

  typedef enum logic [PC_ST_W-1:0] {
    PC_ST_IDLE  = 3'd0,
    PC_ST_RUN   = 3'd1,
    PC_ST_STALL = 3'd2,
    PC_ST_FLUSH = 3'd3,
    PC_ST_HALT  = 3'd4
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter shared by the STALL and FLUSH sequences.
// done flags the last cycle of a sequence (count == 1).
module pipe_ctrl_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PC_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                done
);

  logic [PC_CNT_W-1:0] cnt;

  // Load takes precedence over decrement; the count never wraps below 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == PC_CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: drives fetch enable, branch load and the
// IF/ID flush / ID/EX bubble controls. Outputs are Mealy (no register stage).
// Optional feature: define PIPE_CTRL_PERF_EN to add saturating stall and
// flush cycle counters (oStallCnt, oFlushCnt).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int BR_PENALTY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic       iIdValid,
  input  logic       iIdReadsA,
  input  logic       iIdReadsB,
  input  logic       iIdHalt,
  input  logic       iExLoadA,
  input  logic       iExLoadB,
  input  logic       iBr_taken,
  output logic       oFetchEnable,
  output logic       oBrLoad,
  output logic       oFlush,
  output logic       oIdBubble,
  output logic [2:0] oState
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] oStallCnt,
  output logic [15:0] oFlushCnt
`endif
);

  localparam logic [PC_CNT_W-1:0] STALL_LOAD = PC_CNT_W'(STALL_CYCLES - 1);
  localparam logic [PC_CNT_W-1:0] BR_LOAD    = PC_CNT_W'(BR_PENALTY - 1);
  localparam bit STALL_MULTI = (STALL_CYCLES > 1);
  localparam bit BR_MULTI    = (BR_PENALTY > 1);

  pc_state_e           state, state_n;
  logic                hz;
  logic                cnt_load, cnt_dec, cnt_done;
  logic [PC_CNT_W-1:0] cnt_val;

  assign hz = iIdValid & ((iExLoadA & iIdReadsA) | (iExLoadB & iIdReadsB));

  pipe_ctrl_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // State register; reset aborts any stall or flush in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PC_ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and Mealy outputs; branch beats halt beats load-use hazard.
  always_comb begin
    state_n      = state;
    oFetchEnable = 1'b0;
    oBrLoad      = 1'b0;
    oFlush       = 1'b0;
    oIdBubble    = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    cnt_dec      = 1'b0;
    case (state)
      PC_ST_IDLE, PC_ST_HALT: begin
        oIdBubble = 1'b1;
        if (iStart) state_n = PC_ST_RUN;
      end
      PC_ST_RUN, PC_ST_STALL, PC_ST_FLUSH: begin
        if (iBr_taken) begin
          oBrLoad      = 1'b1;
          oFetchEnable = 1'b1;
          oFlush       = 1'b1;
          oIdBubble    = 1'b1;
          cnt_load     = 1'b1;
          cnt_val      = BR_LOAD;
          state_n      = BR_MULTI ? PC_ST_FLUSH : PC_ST_RUN;
        end else if (iIdHalt && iIdValid) begin
          oIdBubble = 1'b1;
          state_n   = PC_ST_HALT;
        end else if (state == PC_ST_STALL) begin
          oIdBubble = 1'b1;
          cnt_dec   = 1'b1;
          if (cnt_done) state_n = PC_ST_RUN;
        end else if (state == PC_ST_FLUSH) begin
          oFetchEnable = 1'b1;
          oFlush       = 1'b1;
          oIdBubble    = 1'b1;
          cnt_dec      = 1'b1;
          if (cnt_done) state_n = PC_ST_RUN;
        end else if (hz) begin
          // The detection cycle is the first stall cycle.
          oIdBubble = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = STALL_LOAD;
          state_n   = STALL_MULTI ? PC_ST_STALL : PC_ST_RUN;
        end else begin
          oFetchEnable = 1'b1;
        end
      end
      default: begin
        oIdBubble = 1'b1;
        state_n   = PC_ST_IDLE;
      end
    endcase
  end

  assign oState = state;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counts of non-fetching active cycles and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!oFetchEnable && (state != PC_ST_IDLE) && (state != PC_ST_HALT))
        stall_cnt <= sat_inc(stall_cnt);
      if (oFlush)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign oStallCnt = stall_cnt;
  assign oFlushCnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (STALL_CYCLES=3/BR_PENALTY=2 and 1/1)
// share stimulus and are compared every cycle against a countdown model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start, id_valid, id_reads_a, id_reads_b, id_halt, ex_load_a, ex_load_b, br_taken;
  logic [1:0] fe, bl, fl, bu;
  logic [2:0] st0, st1;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_CYCLES(3), .BR_PENALTY(2)) dut0 (
    .clk(clk), .reset(reset), .iStart(start), .iIdValid(id_valid),
    .iIdReadsA(id_reads_a), .iIdReadsB(id_reads_b), .iIdHalt(id_halt),
    .iExLoadA(ex_load_a), .iExLoadB(ex_load_b), .iBr_taken(br_taken),
    .oFetchEnable(fe[0]), .oBrLoad(bl[0]), .oFlush(fl[0]), .oIdBubble(bu[0]),
    .oState(st0)
`ifdef PIPE_CTRL_PERF_EN
    , .oStallCnt(sc0), .oFlushCnt(fc0)
`endif
  );

  pipe_ctrl #(.STALL_CYCLES(1), .BR_PENALTY(1)) dut1 (
    .clk(clk), .reset(reset), .iStart(start), .iIdValid(id_valid),
    .iIdReadsA(id_reads_a), .iIdReadsB(id_reads_b), .iIdHalt(id_halt),
    .iExLoadA(ex_load_a), .iExLoadB(ex_load_b), .iBr_taken(br_taken),
    .oFetchEnable(fe[1]), .oBrLoad(bl[1]), .oFlush(fl[1]), .oIdBubble(bu[1]),
    .oState(st1)
`ifdef PIPE_CTRL_PERF_EN
    , .oStallCnt(sc1), .oFlushCnt(fc1)
`endif
  );

  // Stand-in for the fetch stage PC, driven by dut0.
  logic [9:0] pc;
  logic [9:0] br_dir = 10'd48;
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (bl[0]) pc <= br_dir;
    else if (fe[0]) pc <= pc + 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: active flag plus remaining stall / flush cycles.
  int PS[2] = '{3, 1};
  int PB[2] = '{2, 1};
  int m_on[2], m_halted[2], m_stall[2], m_flush[2], m_sc[2], m_fc[2];
  int s_fe[2], s_bl[2], s_fl[2], s_bu[2], s_st[2];

  function automatic bit hazard();
    return id_valid && ((ex_load_a && id_reads_a) || (ex_load_b && id_reads_b));
  endfunction

  function automatic void model_exp(input int i, output int ef, output int ebl,
                                    output int efl, output int ebu, output int est);
    ef = 0; ebl = 0; efl = 0; ebu = 0;
    if (m_stall[i] > 0) est = 2;
    else if (m_flush[i] > 0) est = 3;
    else est = 1;
    if (!m_on[i]) begin
      ebu = 1;
      est = m_halted[i] ? 4 : 0;
    end else if (br_taken) begin
      ef = 1; ebl = 1; efl = 1; ebu = 1;
    end else if (id_halt && id_valid) begin
      ebu = 1;
    end else if (m_stall[i] > 0) begin
      ebu = 1;
    end else if (m_flush[i] > 0) begin
      ef = 1; efl = 1; ebu = 1;
    end else if (hazard()) begin
      ebu = 1;
    end else begin
      ef = 1;
    end
  endfunction

  function automatic void model_step(input int i, input int ef, input int efl);
    if (m_on[i] && !ef && m_sc[i] < 65535) m_sc[i]++;
    if (efl && m_fc[i] < 65535) m_fc[i]++;
    if (!m_on[i]) begin
      if (start) m_on[i] = 1;
    end else if (br_taken) begin
      m_stall[i] = 0;
      m_flush[i] = PB[i] - 1;
    end else if (id_halt && id_valid) begin
      m_on[i] = 0; m_halted[i] = 1; m_stall[i] = 0; m_flush[i] = 0;
    end else if (m_stall[i] > 0) begin
      m_stall[i]--;
    end else if (m_flush[i] > 0) begin
      m_flush[i]--;
    end else if (hazard()) begin
      m_stall[i] = PS[i] - 1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_halted[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      m_sc[i] = 0; m_fc[i] = 0;
    end
  endfunction

  task automatic clear_inputs();
    start = 0; id_valid = 0; id_reads_a = 0; id_reads_b = 0;
    id_halt = 0; ex_load_a = 0; ex_load_b = 0; br_taken = 0;
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic cyc();
    int ef, ebl, efl, ebu, est;
    #1;
    s_fe[0] = fe[0]; s_bl[0] = bl[0]; s_fl[0] = fl[0]; s_bu[0] = bu[0]; s_st[0] = st0;
    s_fe[1] = fe[1]; s_bl[1] = bl[1]; s_fl[1] = fl[1]; s_bu[1] = bu[1]; s_st[1] = st1;
    for (int i = 0; i < 2; i++) begin
      model_exp(i, ef, ebl, efl, ebu, est);
      chk($sformatf("fetch%0d", i), s_fe[i], ef);
      chk($sformatf("brload%0d", i), s_bl[i], ebl);
      chk($sformatf("flush%0d", i), s_fl[i], efl);
      chk($sformatf("bubble%0d", i), s_bu[i], ebu);
      chk($sformatf("state%0d", i), s_st[i], est);
`ifdef PIPE_CTRL_PERF_EN
      chk($sformatf("stallcnt%0d", i), (i == 0) ? int'(sc0) : int'(sc1), m_sc[i]);
      chk($sformatf("flushcnt%0d", i), (i == 0) ? int'(fc0) : int'(fc1), m_fc[i]);
`endif
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      model_exp(i, ef, ebl, efl, ebu, est);
      model_step(i, ef, efl);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset from the current cycle; outputs must go idle at once.
  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    chk({tag, "_state0"}, st0, 0);
    chk({tag, "_state1"}, st1, 0);
    chk({tag, "_fetch0"}, fe[0], 0);
    chk({tag, "_fetch1"}, fe[1], 0);
    chk({tag, "_bubble0"}, bu[0], 1);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_sc0"}, sc0, 0);
    chk({tag, "_fc0"}, fc0, 0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    bit st, vl, ra, rb, ht, la, lb, br;
    bit ef, ebl, efl, ebu;
    int es;
  } vec_t;

  vec_t tbl[19];
  int n_fe0, n_fe1, n_st2, n_fl0, n_fl1, n_st4;

  initial begin
    // start, valid, rdA, rdB, halt, ldA, ldB, br | fetch, brload, flush, bubble, state (dut0)
    tbl[0]  = '{0,0,0,0,0,0,0,0, 0,0,0,1, 0};
    tbl[1]  = '{1,0,0,0,0,0,0,0, 0,0,0,1, 0};
    tbl[2]  = '{0,0,0,0,0,0,0,0, 1,0,0,0, 1};
    tbl[3]  = '{0,1,1,0,0,1,0,0, 0,0,0,1, 1};
    tbl[4]  = '{0,1,1,0,0,1,0,0, 0,0,0,1, 2};
    tbl[5]  = '{0,1,1,0,0,1,0,0, 0,0,0,1, 2};
    tbl[6]  = '{0,1,0,0,0,0,0,0, 1,0,0,0, 1};
    tbl[7]  = '{0,1,1,0,0,1,0,1, 1,1,1,1, 1};
    tbl[8]  = '{0,0,0,0,0,0,0,0, 1,0,1,1, 3};
    tbl[9]  = '{0,1,0,0,1,0,0,0, 0,0,0,1, 1};
    tbl[10] = '{0,0,0,0,0,0,0,0, 0,0,0,1, 4};
    tbl[11] = '{1,0,0,0,0,0,0,0, 0,0,0,1, 4};
    tbl[12] = '{0,0,0,0,0,0,0,0, 1,0,0,0, 1};
    tbl[13] = '{0,1,0,1,0,0,1,0, 0,0,0,1, 1};
    tbl[14] = '{0,0,0,0,0,0,0,1, 1,1,1,1, 2};
    tbl[15] = '{0,0,0,0,0,0,0,0, 1,0,1,1, 3};
    tbl[16] = '{0,1,0,1,0,1,0,0, 1,0,0,0, 1};
    tbl[17] = '{0,0,1,0,0,1,0,0, 1,0,0,0, 1};
    tbl[18] = '{1,0,0,0,0,0,0,0, 1,0,0,0, 1};

    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", st0, 0);
    chk("rst_fetch", fe[0], 0);
    chk("rst_bubble", bu[0], 1);
    chk("rst_flush", fl[0], 0);
    chk("rst_brload", bl[0], 0);
    reset = 0;

    // Idle with iStart low.
    repeat (5) cyc();

    // Table-driven sequence from IDLE.
    for (int k = 0; k < 19; k++) begin
      start = tbl[k].st; id_valid = tbl[k].vl; id_reads_a = tbl[k].ra;
      id_reads_b = tbl[k].rb; id_halt = tbl[k].ht; ex_load_a = tbl[k].la;
      ex_load_b = tbl[k].lb; br_taken = tbl[k].br;
      cyc();
      chk($sformatf("tbl%0d_fetch", k), s_fe[0], tbl[k].ef);
      chk($sformatf("tbl%0d_brload", k), s_bl[0], tbl[k].ebl);
      chk($sformatf("tbl%0d_flush", k), s_fl[0], tbl[k].efl);
      chk($sformatf("tbl%0d_bubble", k), s_bu[0], tbl[k].ebu);
      chk($sformatf("tbl%0d_state", k), s_st[0], tbl[k].es);
    end
    clear_inputs();
    cyc();

    // Stall length: one hazard cycle, then count non-fetch cycles.
    n_fe0 = 0; n_fe1 = 0; n_st2 = 0;
    id_valid = 1; id_reads_a = 1; ex_load_a = 1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (!s_fe[0]) n_fe0++;
      if (!s_fe[1]) n_fe1++;
      if (s_st[0] == 2) n_st2++;
      clear_inputs();
    end
    chk("stall_len_3", n_fe0, 3);
    chk("stall_len_1", n_fe1, 1);
    chk("stall_state_cycles", n_st2, 2);

    // Taken branch to 48 with a hazard in the same cycle.
    n_fl0 = 0; n_fl1 = 0;
    br_taken = 1; id_valid = 1; id_reads_b = 1; ex_load_b = 1;
    cyc();
    chk("br_brload", s_bl[0], 1);
    chk("br_fetch", s_fe[0], 1);
    chk("br_pc", pc, 48);
    n_fl0 += s_fl[0]; n_fl1 += s_fl[1];
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_fl0 += s_fl[0]; n_fl1 += s_fl[1];
      if (s_st[0] == 2) n_st2++;
    end
    chk("br_flush_len_2", n_fl0, 2);
    chk("br_flush_len_1", n_fl1, 1);
    chk("br_no_stall", n_st2, 2);

    // Halt holds fetch off until iStart.
    n_fe0 = 0; n_st4 = 0;
    id_valid = 1; id_halt = 1;
    cyc();
    clear_inputs();
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_fe[0]) n_fe0++;
      if (s_st[0] == 4) n_st4++;
    end
    chk("halt_fetch_cycles", n_fe0, 0);
    chk("halt_state_cycles", n_st4, 10);
    start = 1;
    cyc();
    clear_inputs();
    cyc();
    chk("halt_restart", s_st[0], 1);

    // Reset in the middle of a 3-cycle stall.
    id_valid = 1; id_reads_a = 1; ex_load_a = 1;
    cyc();
    clear_inputs();
    cyc();
    chk("stall_before_reset", s_st[0], 2);
    do_reset("rst_mid_stall");
    repeat (2) cyc();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_reset");
      end else begin
        start      = ($urandom_range(0, 9) == 0);
        id_valid   = ($urandom_range(0, 9) < 7);
        id_reads_a = $urandom_range(0, 1);
        id_reads_b = $urandom_range(0, 1);
        id_halt    = ($urandom_range(0, 19) == 0);
        ex_load_a  = ($urandom_range(0, 9) < 3);
        ex_load_b  = ($urandom_range(0, 9) < 3);
        br_taken   = ($urandom_range(0, 9) == 0);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
